// File: rtl/dl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dl_pkg                                             |
// | Description : Shared types for the dl shifter pipeline: the      |
// |               shift/rotate operation encoding.                   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package dl_pkg;

  // Codes 5..7 are reserved; the shifter passes data through unchanged.
  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } sh_op_t;

  localparam int SH_OP_BITS = 3;

endpackage : dl_pkg
`default_nettype wire

// File: rtl/dl_shift_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dl_shift_stage                                     |
// | Description : Combinational partial shifter. Applies the shift   |
// |               amount shamt_part << SHIFT_OFFSET for any op.      |
// |               Left ops are done as bit-reversed right ops.       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module dl_shift_stage
  import dl_pkg::*;
#(
  parameter int NUM_BITS     = 32,
  parameter int SHIFT_OFFSET = 0,
  parameter int SHIFT_WIDTH  = 1
) (
  input  logic [NUM_BITS-1:0]    data_in,
  input  logic [SHIFT_WIDTH-1:0] shamt_part,
  input  sh_op_t                 op,
  output logic [NUM_BITS-1:0]    data_out
);

  logic [31:0]         w_amt;
  logic [31:0]         w_rot_amt;
  logic                w_left;
  logic                w_rot;
  logic                w_fill;
  logic [NUM_BITS-1:0] w_src;
  logic [NUM_BITS-1:0] w_mask;
  logic [NUM_BITS-1:0] w_res;
  logic [NUM_BITS-1:0] w_res_rev;

  // Reverse for left ops, shift/rotate right, reverse back; reserved ops pass through
  always_comb begin
    w_amt     = 32'(shamt_part) << SHIFT_OFFSET;
    w_rot_amt = w_amt % 32'(NUM_BITS);
    w_left    = (op == SH_SLL) || (op == SH_ROL);
    w_rot     = (op == SH_ROL) || (op == SH_ROR);
    w_fill    = (op == SH_SRA) && data_in[NUM_BITS-1];
    for (int i = 0; i < NUM_BITS; i++) begin
      w_src[i] = w_left ? data_in[NUM_BITS-1-i] : data_in[i];
    end
    // Bits vacated by a right shift of w_amt; all ones once w_amt >= NUM_BITS
    w_mask = ~({NUM_BITS{1'b1}} >> w_amt);
    if (w_rot) begin
      w_res = (w_src >> w_rot_amt) | (w_src << (32'(NUM_BITS) - w_rot_amt));
    end else begin
      w_res = (w_src >> w_amt) | (w_fill ? w_mask : '0);
    end
    for (int i = 0; i < NUM_BITS; i++) begin
      w_res_rev[i] = w_res[NUM_BITS-1-i];
    end
    case (op)
      SH_SLL, SH_ROL:         data_out = w_res_rev;
      SH_SRL, SH_SRA, SH_ROR: data_out = w_res;
      default:                data_out = data_in;
    endcase
  end

endmodule : dl_shift_stage
`default_nettype wire

// File: rtl/dl_shift_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dl_shift_pipe                                      |
// | Description : Pipelined barrel shifter/rotator with valid/ready  |
// |               handshake. The shift amount is split into groups,  |
// |               LSB group first, one group per register stage.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module dl_shift_pipe
  import dl_pkg::*;
#(
  parameter  int NUM_BITS       = 32,
  parameter  int NUM_STAGES     = 2,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [NUM_BITS-1:0]       in_data,
  input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
  input  sh_op_t                    in_op,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [NUM_BITS-1:0]       out_data
);

  localparam int c_grp_bits = (NUM_SHIFT_BITS + NUM_STAGES - 1) / NUM_STAGES;

  genvar s;
  generate
    for (s = 0; s < NUM_STAGES; s++) begin : g_stage
      // Shamt bits consumed here; trailing stages may get none when groups run out
      localparam int c_off  = (s * c_grp_bits < NUM_SHIFT_BITS) ? s * c_grp_bits : NUM_SHIFT_BITS;
      localparam int c_wid  = (NUM_SHIFT_BITS - c_off < c_grp_bits) ? NUM_SHIFT_BITS - c_off : c_grp_bits;
      localparam int c_cin  = NUM_SHIFT_BITS - c_off;
      localparam int c_cout = c_cin - c_wid;
      localparam int c_shp  = (c_wid > 0) ? c_wid : 1;

      logic                w_in_vld;
      logic [NUM_BITS-1:0] w_in_data;
      logic [2:0]          w_in_op;
      logic [c_shp-1:0]    w_shamt_part;
      logic [NUM_BITS-1:0] w_shifted;
      logic                w_adv;
      logic                w_load;
      logic                w_take;
      logic                r_vld;
      logic [NUM_BITS-1:0] r_data;

      if (s == 0) begin : g_head
        assign w_in_vld  = in_vld;
        assign w_in_data = in_data;
        assign w_in_op   = in_op;
      end else begin : g_body
        assign w_in_vld  = g_stage[s-1].r_vld;
        assign w_in_data = g_stage[s-1].r_data;
        assign w_in_op   = g_stage[s-1].g_fwd.r_op;
      end

      if (c_wid > 0) begin : g_amt
        logic [c_cin-1:0] w_in_sh;
        if (s == 0) begin : g_amt_head
          assign w_in_sh = in_shamt;
        end else begin : g_amt_body
          assign w_in_sh = g_stage[s-1].g_amt.g_carry.r_sh;
        end
        assign w_shamt_part = w_in_sh[c_wid-1:0];

        if (c_cout > 0) begin : g_carry
          logic [c_cout-1:0] r_sh;
          // Forward the not-yet-applied shamt bits with the data
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              r_sh <= '0;
            end else if (w_take) begin
              r_sh <= w_in_sh[c_cin-1:c_wid];
            end
          end
        end
      end else begin : g_noamt
        assign w_shamt_part = 1'b0;
      end

      if (s < NUM_STAGES - 1) begin : g_fwd
        logic [2:0] r_op;
        // Forward the op to the next stage
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_op <= '0;
          end else if (w_take) begin
            r_op <= w_in_op;
          end
        end
      end

      // A stage drains when the one after it loads, or downstream accepts
      if (s == NUM_STAGES - 1) begin : g_tail
        assign w_adv = out_rdy;
      end else begin : g_mid
        assign w_adv = g_stage[s+1].w_load;
      end
      assign w_load = !r_vld || w_adv;
      assign w_take = w_load && w_in_vld;

      dl_shift_stage #(
        .NUM_BITS     (NUM_BITS),
        .SHIFT_OFFSET (c_off),
        .SHIFT_WIDTH  (c_shp)
      ) u_shift (
        .data_in    (w_in_data),
        .shamt_part (w_shamt_part),
        .op         (sh_op_t'(w_in_op)),
        .data_out   (w_shifted)
      );

      // Stage valid/data: load when empty or draining, hold otherwise
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld  <= 1'b0;
          r_data <= '0;
        end else if (w_load) begin
          r_vld <= w_in_vld;
          if (w_in_vld) begin
            r_data <= w_shifted;
          end
        end
      end
    end
  endgenerate

  // Gating with rst_n keeps in_rdy low for the whole reset assertion
  assign in_rdy   = rst_n && g_stage[0].w_load;
  assign out_vld  = g_stage[NUM_STAGES-1].r_vld;
  assign out_data = g_stage[NUM_STAGES-1].r_data;

endmodule : dl_shift_pipe
`default_nettype wire
